// File: rtl/oflow_mem_buffer_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oflow_mem_buffer_sched_pkg
// Description : Shared widths, timeout default and FSM state codes for the
//               OFLOW MEM buffer frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package oflow_mem_buffer_sched_pkg;

    localparam int c_TOTAL_FRAME_NUM_WIDTH       = 8;
    localparam int c_NUM_OF_HISTORY_FRAMES_WIDTH = 2;
    localparam int c_TIMEOUT_CYCLES              = 1024;

    localparam int c_STATE_W = 3;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WR_START = 3'd1;
    localparam logic [2:0] c_ST_WR_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_RD_START = 3'd3;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/oflow_mem_buffer_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : oflow_mem_buffer_frame_scheduler_if
// Description : Core-side request and MEM-buffer FSM handshake bundle.
//               err_timeout exists only with OFLOW_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface oflow_mem_buffer_frame_scheduler_if
    import oflow_mem_buffer_sched_pkg::*;
#(
    parameter int TOTAL_FRAME_NUM_WIDTH       = c_TOTAL_FRAME_NUM_WIDTH,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = c_NUM_OF_HISTORY_FRAMES_WIDTH
) ();

    logic                                   start_frame;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames;
    logic                                   done_write;
    logic                                   done_read;
    logic                                   start_write;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] write_slot;
    logic                                   start_read;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_to_read;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] read_slot;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] counter_of_history_frame;
    logic                                   busy;
    logic                                   frame_done;
    logic                                   err_overrun;
`ifdef OFLOW_SCHED_TIMEOUT_EN
    logic                                   err_timeout;
`endif

    modport master (
        output start_frame, frame_num, num_of_history_frames, done_write, done_read,
        input  start_write, write_slot, start_read, frame_to_read, read_slot,
               counter_of_history_frame, busy, frame_done, err_overrun
`ifdef OFLOW_SCHED_TIMEOUT_EN
        , input err_timeout
`endif
    );

    modport slave (
        input  start_frame, frame_num, num_of_history_frames, done_write, done_read,
        output start_write, write_slot, start_read, frame_to_read, read_slot,
               counter_of_history_frame, busy, frame_done, err_overrun
`ifdef OFLOW_SCHED_TIMEOUT_EN
        , output err_timeout
`endif
    );

endinterface
`default_nettype wire

// File: rtl/oflow_mem_buffer_frame_scheduler_ring.sv
`default_nettype none
// ============================================================================
// Module      : oflow_ring_slot_counter
// Description : History ring write pointer with modulo-(H+1) increment, clear
//               and a combinational "pointer minus k" lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_ring_slot_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             incr_i,
    input  logic [WIDTH-1:0] h_i,
    input  logic [WIDTH-1:0] k_i,
    output logic [WIDTH-1:0] slot_o,
    output logic [WIDTH-1:0] sub_slot_o
);

    logic [WIDTH-1:0] slot_q;
    logic [WIDTH-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (incr_i) begin
            slot_d = (slot_q == h_i) ? '0 : slot_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // k never exceeds H, so the wrapped result always fits in WIDTH bits.
    assign sub_slot_o = (slot_q >= k_i) ? (slot_q - k_i)
                                        : (slot_q + h_i + WIDTH'(1) - k_i);
    assign slot_o     = slot_q;

endmodule
`default_nettype wire

// File: rtl/oflow_mem_buffer_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : oflow_mem_buffer_frame_scheduler
// Description : Per-frame sequencer: one write burst, then one read burst per
//               stored history frame (newest first). Optional watchdog under
//               OFLOW_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_mem_buffer_frame_scheduler
    import oflow_mem_buffer_sched_pkg::*;
#(
    parameter int TOTAL_FRAME_NUM_WIDTH       = c_TOTAL_FRAME_NUM_WIDTH,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = c_NUM_OF_HISTORY_FRAMES_WIDTH
`ifdef OFLOW_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES              = c_TIMEOUT_CYCLES
`endif
) (
    input  logic clk,
    input  logic reset,
    oflow_mem_buffer_frame_scheduler_if.slave bus
);

    localparam int c_FW = TOTAL_FRAME_NUM_WIDTH;
    localparam int c_HW = NUM_OF_HISTORY_FRAMES_WIDTH;

    logic [c_STATE_W-1:0] state_q, state_d;
    logic [c_FW-1:0]      f_q, f_d;
    logic [c_HW-1:0]      h_q, h_d;
    logic [c_HW-1:0]      r_q, r_d;
    logic [c_HW-1:0]      k_q, k_d;
    logic [c_HW-1:0]      stored_q, stored_d;
    logic [c_FW-1:0]      frame_to_read_q;
    logic [c_HW-1:0]      read_slot_q;
    logic                 err_overrun_q;

    logic                 w_ring_clear;
    logic                 w_ring_incr;
    logic                 w_load_rd;
    logic [c_HW-1:0]      w_ws;
    logic [c_HW-1:0]      w_sub_slot;

`ifdef OFLOW_SCHED_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                 err_timeout_q;
    logic                 w_tmo_hit;
`endif

    oflow_ring_slot_counter #(
        .WIDTH (c_HW)
    ) u_ring (
        .clk        (clk),
        .rst        (reset),
        .clear_i    (w_ring_clear),
        .incr_i     (w_ring_incr),
        .h_i        (h_q),
        .k_i        (k_d),
        .slot_o     (w_ws),
        .sub_slot_o (w_sub_slot)
    );

    always_comb begin
        state_d      = state_q;
        f_d          = f_q;
        h_d          = h_q;
        r_d          = r_q;
        k_d          = k_q;
        stored_d     = stored_q;
        w_ring_clear = 1'b0;
        w_ring_incr  = 1'b0;
        w_load_rd    = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.start_frame) begin
                    f_d = bus.frame_num;
                    h_d = bus.num_of_history_frames;
                    // A new history depth invalidates everything stored so far.
                    if (bus.num_of_history_frames != h_q) begin
                        stored_d     = '0;
                        w_ring_clear = 1'b1;
                        r_d          = '0;
                    end else begin
                        r_d = (stored_q < bus.num_of_history_frames) ? stored_q
                                                                     : bus.num_of_history_frames;
                    end
                    state_d = c_ST_WR_START;
                end
            end
            c_ST_WR_START: state_d = c_ST_WR_WAIT;
            c_ST_WR_WAIT: begin
                if (bus.done_write) begin
                    if (stored_q < h_q) begin
                        stored_d = stored_q + c_HW'(1);
                    end
                    if (r_q == '0) begin
                        state_d = c_ST_DONE;
                    end else begin
                        k_d       = c_HW'(1);
                        w_load_rd = 1'b1;
                        state_d   = c_ST_RD_START;
                    end
                end
            end
            c_ST_RD_START: state_d = c_ST_RD_WAIT;
            c_ST_RD_WAIT: begin
                if (bus.done_read) begin
                    if (k_q == r_q) begin
                        state_d = c_ST_DONE;
                    end else begin
                        k_d       = k_q + c_HW'(1);
                        w_load_rd = 1'b1;
                        state_d   = c_ST_RD_START;
                    end
                end
            end
            c_ST_DONE: begin
                w_ring_incr = 1'b1;
                state_d     = c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase

`ifdef OFLOW_SCHED_TIMEOUT_EN
        w_tmo_hit = 1'b0;
        tmo_cnt_d = '0;
        if (((state_q == c_ST_WR_WAIT) || (state_q == c_ST_RD_WAIT)) && (state_d == state_q)) begin
            if (tmo_cnt_q == c_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                w_tmo_hit = 1'b1;
                state_d   = c_ST_DONE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + c_TMO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= c_ST_IDLE;
            f_q             <= '0;
            h_q             <= '0;
            r_q             <= '0;
            k_q             <= '0;
            stored_q        <= '0;
            frame_to_read_q <= '0;
            read_slot_q     <= '0;
            err_overrun_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_q           <= f_d;
            h_q           <= h_d;
            r_q           <= r_d;
            k_q           <= k_d;
            stored_q      <= stored_d;
            err_overrun_q <= bus.start_frame && (state_q != c_ST_IDLE);
            if (w_load_rd) begin
                frame_to_read_q <= f_q - c_FW'(k_d);
                read_slot_q     <= w_sub_slot;
            end
        end
    end

`ifdef OFLOW_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (w_tmo_hit) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.err_timeout = err_timeout_q;
`endif

    assign bus.start_write              = (state_q == c_ST_WR_START);
    assign bus.start_read               = (state_q == c_ST_RD_START);
    assign bus.frame_done               = (state_q == c_ST_DONE);
    assign bus.busy                     = (state_q != c_ST_IDLE);
    assign bus.write_slot               = w_ws;
    assign bus.frame_to_read            = frame_to_read_q;
    assign bus.read_slot                = read_slot_q;
    assign bus.counter_of_history_frame = k_q;
    assign bus.err_overrun              = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_oflow_mem_buffer_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_oflow_mem_buffer_frame_scheduler
// Description : Self-checking bench: directed frame table plus randomized
//               frames against a history-ring reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oflow_mem_buffer_frame_scheduler;

    typedef struct {
        int f;
        int h;
        int wdly;
        int rdly;
        bit spur;
        bit ovr;
        bit sfd;
        bit rstm;
        int exp_r;
        int exp_ws;
    } vec_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: previous depth, frames stored, ring write pointer.
    int m_prev_h;
    int m_stored;
    int m_ws;

    vec_t tab [19];

    oflow_mem_buffer_frame_scheduler_if bus ();

    oflow_mem_buffer_frame_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input bit use_tab);
        int  r;
        int  ws;
        bit  noisy;
        bit  spurious_done;
        if (v.h != m_prev_h) begin
            m_stored = 0;
            m_ws     = 0;
        end
        r  = (m_stored < v.h) ? m_stored : v.h;
        ws = m_ws;
        if (use_tab) begin
            r  = v.exp_r;
            ws = v.exp_ws;
        end
        noisy = 1'b0;

        bus.start_frame           = 1'b1;
        bus.frame_num             = 8'(v.f);
        bus.num_of_history_frames = 2'(v.h);
        tick();
        bus.start_frame = 1'b0;
        check("busy_on", bus.busy, 1);
        check("start_write", bus.start_write, 1);
        check("write_slot", bus.write_slot, ws);
        check("no_overrun", bus.err_overrun, 0);

        tick();
        for (int i = 0; i < v.wdly; i++) begin
            bus.done_read = v.spur;
            tick();
            if (bus.start_read || bus.frame_done || bus.start_write) noisy = 1'b1;
        end
        bus.done_read  = 1'b0;
        bus.done_write = 1'b1;
        tick();
        bus.done_write = 1'b0;

        for (int k = 1; k <= r; k++) begin
            check("start_read", bus.start_read, 1);
            check("frame_to_read", bus.frame_to_read, (v.f - k) & 255);
            check("read_slot", bus.read_slot, (ws - k + v.h + 1) % (v.h + 1));
            check("hist_counter", bus.counter_of_history_frame, k);
            tick();
            if (v.rstm) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("rst_busy", bus.busy, 0);
                check("rst_outs", {bus.start_write, bus.start_read, bus.frame_done, bus.err_overrun}, 0);
                check("rst_frame_to_read", bus.frame_to_read, 0);
                check("rst_slots", {bus.write_slot, bus.read_slot, bus.counter_of_history_frame}, 0);
                spurious_done = 1'b0;
                repeat (4) begin
                    tick();
                    if (bus.frame_done) spurious_done = 1'b1;
                end
                check("rst_no_frame_done", spurious_done, 0);
                m_prev_h = 0;
                m_stored = 0;
                m_ws     = 0;
                return;
            end
            if (v.ovr && k == 1) begin
                bus.start_frame           = 1'b1;
                bus.frame_num             = 8'(v.f) ^ 8'hA5;
                bus.num_of_history_frames = 2'(v.h) ^ 2'b01;
                tick();
                bus.start_frame           = 1'b0;
                bus.num_of_history_frames = 2'(v.h);
                check("overrun_pulse", bus.err_overrun, 1);
            end
            for (int i = 0; i < v.rdly; i++) begin
                bus.done_write = v.spur;
                tick();
                if (bus.start_read || bus.frame_done) noisy = 1'b1;
            end
            bus.done_write = 1'b0;
            bus.done_read  = 1'b1;
            tick();
            bus.done_read = 1'b0;
        end

        check("frame_done", bus.frame_done, 1);
        check("no_read_at_done", bus.start_read, 0);
        check("wait_quiet", noisy, 0);

        if (v.sfd) begin
            bus.start_frame = 1'b1;
            tick();
            bus.start_frame = 1'b0;
            check("overrun_at_done", bus.err_overrun, 1);
            check("not_accepted", bus.start_write, 0);
        end else begin
            tick();
        end
        check("busy_off", bus.busy, 0);

        m_stored = (m_stored + 1 < v.h) ? m_stored + 1 : v.h;
        m_ws     = (m_ws + 1) % (v.h + 1);
        m_prev_h = v.h;
    endtask

    initial begin
        vec_t rv;
        reset                     = 1'b1;
        bus.start_frame           = 1'b0;
        bus.frame_num             = '0;
        bus.num_of_history_frames = '0;
        bus.done_write            = 1'b0;
        bus.done_read             = 1'b0;
        m_prev_h = 0;
        m_stored = 0;
        m_ws     = 0;

        //           f    h wd rd sp ov sf rm  R ws
        tab[0]  = '{  0, 3, 3, 0, 0, 0, 0, 0, 0, 0};
        tab[1]  = '{  1, 3, 0, 0, 0, 0, 0, 0, 1, 1};
        tab[2]  = '{  2, 3, 1, 1, 1, 0, 0, 0, 2, 2};
        tab[3]  = '{  3, 3, 0, 2, 0, 0, 0, 0, 3, 3};
        tab[4]  = '{  4, 3, 0, 0, 0, 0, 1, 0, 3, 0};
        tab[5]  = '{254, 3, 2, 0, 0, 0, 0, 0, 3, 1};
        tab[6]  = '{255, 3, 0, 1, 0, 0, 0, 0, 3, 2};
        tab[7]  = '{  0, 3, 0, 0, 0, 0, 0, 0, 3, 3};
        tab[8]  = '{  1, 3, 1, 1, 0, 1, 0, 0, 3, 0};
        tab[9]  = '{  2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[10] = '{  3, 2, 1, 1, 1, 0, 0, 0, 1, 1};
        tab[11] = '{  9, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[12] = '{ 10, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        tab[13] = '{ 11, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[14] = '{ 12, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        tab[15] = '{ 13, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        tab[16] = '{ 20, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[17] = '{ 21, 3, 0, 0, 0, 0, 0, 1, 1, 1};
        tab[18] = '{ 22, 3, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) tick();
        check("reset_busy", bus.busy, 0);
        check("reset_pulses", {bus.start_write, bus.start_read, bus.frame_done, bus.err_overrun}, 0);
        check("reset_write_slot", bus.write_slot, 0);
        check("reset_frame_to_read", bus.frame_to_read, 0);
        check("reset_read_slot", bus.read_slot, 0);
        check("reset_counter", bus.counter_of_history_frame, 0);
        reset = 1'b0;
        tick();

        // Completion strobes while idle must not start anything.
        bus.done_write = 1'b1;
        bus.done_read  = 1'b1;
        tick();
        bus.done_write = 1'b0;
        bus.done_read  = 1'b0;
        tick();
        check("idle_spur_busy", bus.busy, 0);
        check("idle_spur_done", bus.frame_done, 0);

        for (int i = 0; i < 19; i++) begin
            run_frame(tab[i], 1'b1);
        end

        for (int n = 0; n < 60; n++) begin
            rv.f    = int'($urandom_range(0, 255));
            rv.h    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : m_prev_h;
            rv.wdly = int'($urandom_range(0, 3));
            rv.rdly = int'($urandom_range(0, 3));
            rv.spur = 1'($urandom_range(0, 1));
            rv.ovr  = ($urandom_range(0, 5) == 0);
            rv.sfd  = ($urandom_range(0, 5) == 0);
            rv.rstm = 1'b0;
            rv.exp_r  = 0;
            rv.exp_ws = 0;
            run_frame(rv, 1'b0);
        end

`ifdef OFLOW_SCHED_TIMEOUT_EN
        begin
            bit got_done;
            got_done        = 1'b0;
            bus.start_frame = 1'b1;
            bus.frame_num   = 8'd77;
            tick();
            bus.start_frame = 1'b0;
            for (int i = 0; i < 1100 && !got_done; i++) begin
                tick();
                if (bus.frame_done) got_done = 1'b1;
            end
            check("timeout_frame_done", got_done, 1);
            check("timeout_flag", bus.err_timeout, 1);
            repeat (3) tick();
            check("timeout_sticky", bus.err_timeout, 1);
            check("timeout_idle", bus.busy, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
